// File: rtl/hrm_pkg.sv
// Shared HRM definitions: dump-mux select codes, default frame marker,
// dump-sequencer state encoding and the frame checksum helper.
package hrm_pkg;

    localparam logic [2:0] DMP_INBOX  = 3'd0;
    localparam logic [2:0] DMP_OUTBOX = 3'd1;
    localparam logic [2:0] DMP_PC     = 3'd2;
    localparam logic [2:0] DMP_RAM    = 3'd3;
    localparam logic [2:0] DMP_REG    = 3'd4;
    localparam logic [2:0] DMP_INSTR  = 3'd5;

    localparam logic [7:0] HDR_BYTE_DFLT = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_HDR      = 4'd1,
        ST_PC       = 4'd2,
        ST_IR       = 4'd3,
        ST_R        = 4'd4,
        ST_CNT_IN   = 4'd5,
        ST_EMIT_CNT = 4'd6,
        ST_SEND_IN  = 4'd7,
        ST_CNT_OUT  = 4'd8,
        ST_SEND_OUT = 4'd9,
        ST_CKSUM    = 4'd10
    } dump_state_e;

    function automatic logic [7:0] cksum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/hrm_dump_seq_if.sv
// Dump-mux and host byte-stream signals between the dump sequencer (master)
// and the core / UART side (slave).
interface hrm_dump_seq_if #(
    parameter int LGFLEN = 5
);
    logic [2:0]        dmp_sel;
    logic [LGFLEN-1:0] dmp_pos;
    logic [7:0]        dmp_data;
    logic              dmp_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output dmp_sel, dmp_pos, tx_data, tx_valid,
        input  dmp_data, dmp_valid, tx_ready
    );

    modport slave (
        input  dmp_sel, dmp_pos, tx_data, tx_valid,
        output dmp_data, dmp_valid, tx_ready
    );
endinterface

// File: rtl/hrm_tx_hold.sv
// One-entry output register for the byte stream: a loaded byte stays valid
// and unchanged until the sink accepts it.
module hrm_tx_hold (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] data
);
    logic       valid_r;
    logic [7:0] data_r;

    // Capture on load, drop valid on handshake, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= 8'h00;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
endmodule

// File: rtl/hrm_dump_seq.sv
// HRM debug-dump sequencer: walks PC, IR, R, INBOX, OUTBOX via the core dump mux
// and emits a length-prefixed byte frame. Optional trailing XOR byte: HRM_DUMP_CKSUM_EN.
module hrm_dump_seq
    import hrm_pkg::*;
#(
    parameter int         LGFLEN   = 5,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DFLT
) (
    input  logic           clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    output logic           o_busy,
    output logic           o_hold,
    hrm_dump_seq_if.master bus
);
    localparam logic [LGFLEN-1:0] POS_ZERO = {LGFLEN{1'b0}};
    localparam logic [LGFLEN-1:0] POS_ONE  = {{(LGFLEN-1){1'b0}}, 1'b1};
    localparam logic [LGFLEN-1:0] POS_MAX  = {LGFLEN{1'b1}};
    localparam logic [LGFLEN:0]   CNT_ZERO = {(LGFLEN+1){1'b0}};
    localparam logic [LGFLEN:0]   CNT_ONE  = {{LGFLEN{1'b0}}, 1'b1};
    localparam int                PAD_W    = 8 - (LGFLEN + 1);
`ifdef HRM_DUMP_CKSUM_EN
    localparam dump_state_e FINAL_ST = ST_CKSUM;
`else
    localparam dump_state_e FINAL_ST = ST_IDLE;
`endif

    dump_state_e       state_r, state_s;
    logic [2:0]        sel_r, sel_s;
    logic [LGFLEN-1:0] pos_r, pos_s;
    logic [LGFLEN:0]   count_r, count_s;
    logic              last_r, last_s;
    logic              busy_r;
    logic              load_s;
    logic [7:0]        load_data_s;
    logic              tx_valid_s;
    logic [7:0]        tx_data_s;
    logic              fire_s;
`ifdef HRM_DUMP_CKSUM_EN
    logic [7:0]        acc_r;
`endif

    assign fire_s = tx_valid_s & bus.tx_ready;

    // Next-state and datapath decode; emit states load once, then wait for the handshake.
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        pos_s       = pos_r;
        count_s     = count_r;
        last_s      = last_r;
        load_s      = 1'b0;
        load_data_s = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (i_start) state_s = ST_HDR;
                else         state_s = ST_IDLE;
            end
            ST_HDR, ST_PC, ST_IR, ST_R: begin
                if (!tx_valid_s) begin
                    load_s      = 1'b1;
                    load_data_s = (state_r == ST_HDR) ? HDR_BYTE : bus.dmp_data;
                end else if (fire_s) begin
                    case (state_r)
                        ST_HDR:  state_s = ST_PC;
                        ST_PC:   begin state_s = ST_IR; sel_s = DMP_INSTR; end
                        ST_IR:   begin state_s = ST_R;  sel_s = DMP_REG;   end
                        default: begin
                            state_s = ST_CNT_IN;
                            sel_s   = DMP_INBOX;
                            pos_s   = POS_ZERO;
                            count_s = CNT_ZERO;
                        end
                    endcase
                end else begin
                    state_s = state_r;
                end
            end
            // A full FIFO wraps pos back to 0 on its own.
            ST_CNT_IN, ST_CNT_OUT: begin
                if (bus.dmp_valid) begin
                    count_s = count_r + CNT_ONE;
                    pos_s   = pos_r + POS_ONE;
                    if (pos_r == POS_MAX) state_s = ST_EMIT_CNT;
                    else                  state_s = state_r;
                end else begin
                    state_s = ST_EMIT_CNT;
                    pos_s   = POS_ZERO;
                end
            end
            ST_EMIT_CNT: begin
                if (!tx_valid_s) begin
                    load_s      = 1'b1;
                    load_data_s = {{PAD_W{1'b0}}, count_r};
                end else if (fire_s) begin
                    if (count_r != CNT_ZERO) begin
                        if (sel_r == DMP_INBOX) state_s = ST_SEND_IN;
                        else                    state_s = ST_SEND_OUT;
                    end else if (sel_r == DMP_INBOX) begin
                        state_s = ST_CNT_OUT;
                        sel_s   = DMP_OUTBOX;
                        pos_s   = POS_ZERO;
                        count_s = CNT_ZERO;
                    end else begin
                        state_s = FINAL_ST;
                        sel_s   = DMP_PC;
                        pos_s   = POS_ZERO;
                    end
                end else begin
                    state_s = ST_EMIT_CNT;
                end
            end
            // pos only advances after a handshake so it never passes count-1.
            ST_SEND_IN, ST_SEND_OUT: begin
                if (!tx_valid_s) begin
                    load_s      = 1'b1;
                    load_data_s = bus.dmp_data;
                    last_s      = ({1'b0, pos_r} == (count_r - CNT_ONE));
                end else if (fire_s) begin
                    if (!last_r) begin
                        pos_s = pos_r + POS_ONE;
                    end else if (state_r == ST_SEND_IN) begin
                        state_s = ST_CNT_OUT;
                        sel_s   = DMP_OUTBOX;
                        pos_s   = POS_ZERO;
                        count_s = CNT_ZERO;
                    end else begin
                        state_s = FINAL_ST;
                        sel_s   = DMP_PC;
                        pos_s   = POS_ZERO;
                    end
                end else begin
                    state_s = state_r;
                end
            end
`ifdef HRM_DUMP_CKSUM_EN
            ST_CKSUM: begin
                if (!tx_valid_s) begin
                    load_s      = 1'b1;
                    load_data_s = acc_r;
                end else if (fire_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CKSUM;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                sel_s   = DMP_PC;
                pos_s   = POS_ZERO;
            end
        endcase
    end

    // State, mux selection, counters and busy flag.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            sel_r   <= DMP_PC;
            pos_r   <= POS_ZERO;
            count_r <= CNT_ZERO;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sel_r   <= sel_s;
            pos_r   <= pos_s;
            count_r <= count_s;
            last_r  <= last_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

`ifdef HRM_DUMP_CKSUM_EN
    // XOR of every byte loaded since the accepted start.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_r <= 8'h00;
        end else if ((state_r == ST_IDLE) && i_start) begin
            acc_r <= 8'h00;
        end else if (load_s) begin
            acc_r <= cksum_step(acc_r, load_data_s);
        end else begin
            acc_r <= acc_r;
        end
    end
`endif

    hrm_tx_hold u_tx_hold (
        .clk       (clk),
        .rst_n     (i_rst_n),
        .load      (load_s),
        .load_data (load_data_s),
        .ready     (bus.tx_ready),
        .valid     (tx_valid_s),
        .data      (tx_data_s)
    );

    assign bus.tx_valid = tx_valid_s;
    assign bus.tx_data  = tx_data_s;
    assign bus.dmp_sel  = sel_r;
    assign bus.dmp_pos  = pos_r;
    assign o_busy       = busy_r;
    assign o_hold       = busy_r;
endmodule

// File: tb/tb_hrm_dump_seq.sv
// Self-checking bench for hrm_dump_seq: a core dump-mux model feeds the DUT and
// every received frame is compared against a frame built from the layout rules.
module tb_hrm_dump_seq;
    import hrm_pkg::*;

    localparam int LGFLEN = 5;
    localparam int DEPTH  = 1 << LGFLEN;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, hold;

    hrm_dump_seq_if #(.LGFLEN(LGFLEN)) bus ();

    hrm_dump_seq #(.LGFLEN(LGFLEN), .HDR_BYTE(8'hA5)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .o_busy  (busy),
        .o_hold  (hold),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] pc_v = 8'h00, ir_v = 8'h00, r_v = 8'h00;
    logic [7:0] inbox  [DEPTH];
    logic [7:0] outbox [DEPTH];
    int n_in = 0, n_out = 0;

    // Core dump mux model: FIFO slots are valid below their fill level.
    always_comb begin
        bus.dmp_data  = 8'h00;
        bus.dmp_valid = 1'b0;
        case (bus.dmp_sel)
            DMP_INBOX:  begin bus.dmp_valid = (int'(bus.dmp_pos) < n_in);  bus.dmp_data = inbox[bus.dmp_pos];  end
            DMP_OUTBOX: begin bus.dmp_valid = (int'(bus.dmp_pos) < n_out); bus.dmp_data = outbox[bus.dmp_pos]; end
            DMP_PC:     begin bus.dmp_valid = 1'b1; bus.dmp_data = pc_v; end
            DMP_REG:    begin bus.dmp_valid = 1'b1; bus.dmp_data = r_v;  end
            DMP_INSTR:  begin bus.dmp_valid = 1'b1; bus.dmp_data = ir_v; end
            default:    begin bus.dmp_valid = 1'b0; bus.dmp_data = 8'h00; end
        endcase
    end

    int n_cmp = 0, n_err = 0;
    int rdy_mode = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int max_in_pos = -1;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Byte collector; inputs only change just after posedge, so negedge sees the handshake.
    always @(negedge clk) begin
        if (rst_n && bus.tx_valid && bus.tx_ready) begin
            rx_q.push_back(bus.tx_data);
            last_hs_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = ($urandom_range(0, 3) != 0);
            default: bus.tx_ready = 1'b0;
        endcase
    endtask

    task automatic build_exp();
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(pc_v);
        exp_q.push_back(ir_v);
        exp_q.push_back(r_v);
        exp_q.push_back(8'(n_in));
        for (int i = 0; i < n_in; i++) exp_q.push_back(inbox[i]);
        exp_q.push_back(8'(n_out));
        for (int i = 0; i < n_out; i++) exp_q.push_back(outbox[i]);
`ifdef HRM_DUMP_CKSUM_EN
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`else
        x = 8'h00;
`endif
    endtask

    task automatic run_frame(input string tag, input bit stall_pc, input int extra_start);
        int  base;
        int  n_stall;
        bit  done;
        bit  stalling;
        build_exp();
        base       = rx_q.size();
        max_in_pos = -1;
        n_stall    = 0;
        done       = 1'b0;
        tick();
        start = 1'b1;
        for (int k = 0; k < 4000 && !done; k++) begin
            tick();
            start    = (k == extra_start);
            stalling = 1'b0;
            if (stall_pc && n_stall < 5 && bus.tx_valid && bus.tx_data == 8'h07) begin
                bus.tx_ready = 1'b0;
                n_stall++;
                stalling = 1'b1;
            end
            @(negedge clk);
            if (stalling) begin
                check({tag, " stall valid"}, bus.tx_valid, 1'b1);
                check({tag, " stall data"}, bus.tx_data, 8'h07);
            end
            if (bus.tx_valid && bus.dmp_sel == DMP_INBOX && int'(bus.dmp_pos) > max_in_pos)
                max_in_pos = int'(bus.dmp_pos);
            if (!busy) done = 1'b1;
        end
        start = 1'b0;
        check({tag, " done"}, done, 1'b1);
        check({tag, " busy fall latency"}, cyc - last_hs_cyc, 1);
        check({tag, " length"}, rx_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && (base + i) < rx_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), rx_q[base + i], exp_q[i]);
        check({tag, " sel idle"}, bus.dmp_sel, DMP_PC);
        check({tag, " pos idle"}, bus.dmp_pos, 0);
        check({tag, " hold idle"}, hold, 1'b0);
    endtask

    initial begin
        int  base;
        bit  found;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin inbox[i] = 8'h00; outbox[i] = 8'h00; end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy", busy, 1'b0);
        check("rst valid", bus.tx_valid, 1'b0);
        check("rst data", bus.tx_data, 8'h00);
        check("rst sel", bus.dmp_sel, DMP_PC);
        check("rst pos", bus.dmp_pos, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Empty FIFOs
        pc_v = 8'h07; ir_v = 8'h20; r_v = 8'h11; n_in = 0; n_out = 0;
        rdy_mode = 0;
        run_frame("empty", 1'b0, -1);

        // Three INBOX entries, one OUTBOX entry
        inbox[0] = 8'h03; inbox[1] = 8'h04; inbox[2] = 8'h05; n_in = 3;
        outbox[0] = 8'h09; n_out = 1;
        run_frame("in3", 1'b0, -1);
        check("in3 max send pos", max_in_pos, 2);

        // Full INBOX with random backpressure
        for (int i = 0; i < DEPTH; i++) inbox[i] = 8'(i);
        n_in = DEPTH;
        outbox[0] = 8'h5A; outbox[1] = 8'hC3; n_out = 2;
        rdy_mode = 1;
        run_frame("full", 1'b0, -1);

        // Backpressure on the PC byte
        pc_v = 8'h07; ir_v = 8'h30; r_v = 8'h44;
        inbox[0] = 8'h12; inbox[1] = 8'h34; n_in = 2; n_out = 0;
        rdy_mode = 0;
        run_frame("bp", 1'b1, -1);

        // Start while busy is ignored; a later start gives exactly one frame
        run_frame("busy_start", 1'b0, 10);
        base = rx_q.size();
        repeat (10) tick();
        @(negedge clk);
        check("busy_start stays idle", busy, 1'b0);
        check("busy_start no extra bytes", rx_q.size(), base);
        run_frame("second", 1'b0, -1);

        // Reset during SEND_IN
        for (int i = 0; i < 5; i++) inbox[i] = 8'($urandom_range(0, 255));
        n_in = 5; n_out = 1;
        found = 1'b0;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (bus.tx_valid && bus.dmp_sel == DMP_INBOX && bus.dmp_pos == 5'd1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("midrst reached send_in", found, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst valid", bus.tx_valid, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst sel", bus.dmp_sel, DMP_PC);
        check("midrst pos", bus.dmp_pos, 0);
        tick(); tick();
        rst_n = 1'b1;
        run_frame("after_rst", 1'b0, -1);

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            pc_v = 8'($urandom_range(0, 255));
            ir_v = 8'($urandom_range(0, 255));
            r_v  = 8'($urandom_range(0, 255));
            n_in  = (f == 0) ? DEPTH : $urandom_range(0, DEPTH);
            n_out = (f == 1) ? DEPTH : $urandom_range(0, DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                inbox[i]  = 8'($urandom_range(0, 255));
                outbox[i] = 8'($urandom_range(0, 255));
            end
            rdy_mode = f % 2;
            run_frame($sformatf("rand%0d", f), 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
